// File: rtl/attention_vector_assembler_if.sv
// -----------------------------------------------------------------------------
// attention_vector_assembler_if
// Bundles the serial sample stream, the stall request and the parallel
// attention-bus outputs of attention_vector_assembler.
//   s_data/s_valid/s_last/s_ready : serial channel stream (valid/ready)
//   vec_stall                     : defer emission of the pending vector
//   vec_out/vec_valid             : assembled vector, index = channel
//   frame_err                     : one-cycle pulse per malformed frame
//   vec_count/err_count           : emitted vectors / frame errors
// master = stream source and attention-bus consumer, slave = assembler.
// -----------------------------------------------------------------------------
interface attention_vector_assembler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 16
);
  logic signed [DATA_WIDTH-1:0]      s_data;
  logic                              s_valid;
  logic                              s_last;
  logic                              s_ready;
  logic                              vec_stall;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] vec_out;
  logic                              vec_valid;
  logic                              frame_err;
  logic [15:0]                       vec_count;
  logic [7:0]                        err_count;

  modport master (
    output s_data, s_valid, s_last, vec_stall,
    input  s_ready, vec_out, vec_valid, frame_err, vec_count, err_count
  );

  modport slave (
    input  s_data, s_valid, s_last, vec_stall,
    output s_ready, vec_out, vec_valid, frame_err, vec_count, err_count
  );
endinterface

// File: rtl/attention_vector_assembler.sv
// -----------------------------------------------------------------------------
// attention_vector_assembler
// Assembles a serial signed channel stream into NUM_CH-wide vectors for the
// attention stage. A fill bank collects channels; a completed vector moves to
// the pending bank and is issued with a one-cycle vec_valid pulse when
// vec_stall is low. Short and long frames are dropped and counted.
// Ports:
//   clk    : clock
//   rst    : synchronous, active-high reset
//   io_bus : attention_vector_assembler_if.slave (stream in, vector bus out)
// -----------------------------------------------------------------------------
// state      | meaning
// ST_FILL    | assembling a vector, ch_idx = next channel slot
// ST_DISCARD | dropping beats of a long frame up to and including s_last
module attention_vector_assembler #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  attention_vector_assembler_if.slave   io_bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);

  localparam logic [0:0] ST_FILL    = 1'b0;
  localparam logic [0:0] ST_DISCARD = 1'b1;

  logic [0:0]                        r_state;
  logic [CH_W-1:0]                   r_ch_idx;
  logic                              r_pend_full;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] r_fill;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] r_pend;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] r_vec_out;
  logic                              r_vec_valid;
  logic                              r_frame_err;
  logic [15:0]                       r_vec_count;
  logic [7:0]                        r_err_count;

  logic                              w_in_fill;
  logic                              w_is_last;
  logic                              w_s_ready;
  logic                              w_accept;
  logic                              w_emit;
  logic                              w_complete;
  logic                              w_frame_bad;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] w_new_vec;

  assign w_in_fill = (r_state == ST_FILL);
  assign w_is_last = (r_ch_idx == LAST_IDX);

  // Only the completing beat needs a free pending bank; an emission in the
  // same cycle frees it, so stall is the only thing that can block it.
  assign w_s_ready  = !w_in_fill || !(w_is_last && r_pend_full && io_bus.vec_stall);
  assign w_accept   = io_bus.s_valid && w_s_ready;
  assign w_emit     = r_pend_full && !io_bus.vec_stall;
  assign w_complete = w_accept && w_in_fill && w_is_last && io_bus.s_last;
  // Malformed frame: s_last early (short) or missing on the final slot (long).
  assign w_frame_bad = w_accept && w_in_fill && (w_is_last != io_bus.s_last);

  always_comb begin
    w_new_vec             = r_fill;
    w_new_vec[NUM_CH-1]   = io_bus.s_data;
  end

  // Data banks carry no reset; pend_full/ch_idx qualify their contents.
  always_ff @(posedge clk) begin
    if (w_accept && w_in_fill && !w_is_last && !io_bus.s_last)
      r_fill[r_ch_idx] <= io_bus.s_data;
    if (w_complete)
      r_pend <= w_new_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_FILL;
      r_ch_idx    <= '0;
      r_pend_full <= 1'b0;
      r_vec_out   <= '0;
      r_vec_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_vec_count <= '0;
      r_err_count <= '0;
    end else begin
      r_vec_valid <= 1'b0;
      r_frame_err <= w_frame_bad;

      if (w_frame_bad && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 8'd1;

      if (w_emit) begin
        r_vec_out   <= r_pend;
        r_vec_valid <= 1'b1;
        r_vec_count <= r_vec_count + 16'd1;
      end

      if (w_complete)
        r_pend_full <= 1'b1;
      else if (w_emit)
        r_pend_full <= 1'b0;

      if (w_accept) begin
        if (w_in_fill) begin
          if (w_is_last || io_bus.s_last)
            r_ch_idx <= '0;
          else
            r_ch_idx <= r_ch_idx + CH_W'(1);
          if (w_is_last && !io_bus.s_last)
            r_state <= ST_DISCARD;
        end else if (io_bus.s_last) begin
          r_state  <= ST_FILL;
          r_ch_idx <= '0;
        end
      end
    end
  end

  assign io_bus.s_ready   = w_s_ready;
  assign io_bus.vec_out   = r_vec_out;
  assign io_bus.vec_valid = r_vec_valid;
  assign io_bus.frame_err = r_frame_err;
  assign io_bus.vec_count = r_vec_count;
  assign io_bus.err_count = r_err_count;
endmodule

// File: doc/attention_vector_assembler.md
Name: attention_vector_assembler

Overview:
Front-end feeder for the temporal multi-head attention stage. It takes a serial channel stream (one signed sample per beat, valid/ready, with an end-of-vector marker) and assembles NUM_CH-wide parallel vectors. Each vector is issued with a single-cycle vec_valid pulse onto the attention input bus, which has no backpressure. A double buffer (fill bank plus pending bank) absorbs a downstream stall request. Malformed frames are detected, dropped and counted.

Parameters:
DATA_WIDTH, 16, sample width (signed two's complement)
NUM_CH, 16, channels per assembled vector (>=1)
CH_W, $clog2(NUM_CH) (min 1), channel index width (localparam)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_data  in  DATA_WIDTH (signed)  serial channel sample, channel order 0..NUM_CH-1
s_valid  in  1  s_data/s_last valid
s_last  in  1  marks final channel of a vector
s_ready  out  1  beat accepted when s_valid && s_ready
vec_stall  in  1  defer emission of the pending vector
vec_out  out  NUM_CH x DATA_WIDTH (signed)  assembled vector, index = channel
vec_valid  out  1  one-cycle pulse; vec_out is valid in that cycle and held until the next pulse
frame_err  out  1  one-cycle pulse per malformed frame
vec_count  out  16  vectors emitted, wraps at 2^16
err_count  out  8  frame errors, saturates at 255

Behaviour:
- Reset: vec_out all 0, vec_valid 0, frame_err 0, vec_count 0, err_count 0, ch_idx 0, pend_full 0, state FILL. Fill/pend banks need not be cleared.
- Reset mid-frame discards all partial and pending data.
- States:
  - FILL: assembling a vector.
  - DISCARD: dropping beats up to and including the next s_last.
- s_ready (combinational):
  - FILL: 1, except 0 when ch_idx==NUM_CH-1 && pend_full && vec_stall.
  - DISCARD: always 1.
- Accepted beat in FILL, ch_idx<NUM_CH-1, s_last=0: fill[ch_idx]<=s_data; ch_idx++.
- Accepted beat in FILL, ch_idx<NUM_CH-1, s_last=1 (short frame): partial vector dropped; ch_idx<=0; frame_err=1 next cycle; err_count+1 (saturating); state stays FILL.
- Accepted beat in FILL, ch_idx==NUM_CH-1, s_last=1 (complete): pend<=fill with channel NUM_CH-1 = s_data; pend_full<=1; ch_idx<=0.
- Accepted beat in FILL, ch_idx==NUM_CH-1, s_last=0 (long frame): vector dropped, no pend write; frame_err pulse; err_count+1; ch_idx<=0; state->DISCARD.
- DISCARD: each accepted beat is dropped. The beat with s_last=1 returns state to FILL, ch_idx=0. No additional error is raised.
- Emission: when pend_full && !vec_stall:
  - vec_out<=pend and vec_valid<=1 next cycle;
  - vec_count+1 (wrapping);
  - pend_full<=0, unless a completing beat is accepted in the same cycle, in which case pend takes the new vector and pend_full stays 1.
- Latency: completing beat accepted at cycle T -> pend_full at T+1 -> vec_valid at T+2 if vec_stall=0 at T+1.
- Throughput: one vector per NUM_CH beats is sustained with no bubbles. Back-to-back vec_valid is possible when NUM_CH=1.
- vec_stall held high: first complete vector waits in pend, a second vector fills, and s_ready drops only on that vector's last channel. No data loss, no duplication.
- vec_valid is never asserted for a dropped or erroneous frame. vec_out is unchanged except on emission.
- NUM_CH=1: every beat must carry s_last. A beat without s_last is a long-frame error.

Test Plan:
- NUM_CH=4, stall 0: beats 1,-2,3,-4 (last on -4) in consecutive cycles -> vec_valid one cycle, 2 cycles after the -4 beat; vec_out={1,-2,3,-4}; vec_count=1; s_ready constantly 1.
- Continuous 3 vectors (12 beats, no gaps) -> 3 vec_valid pulses spaced exactly 4 cycles apart, correct contents in order, no s_ready drop.
- Short frame 5,6(last), then valid vector 7,8,9,10 -> frame_err 1 pulse, err_count=1, exactly one vec_valid with {7,8,9,10}.
- Long frame 1,2,3,4(no last),5,6(last), then 11,12,13,14(last) -> one frame_err, 5 and 6 dropped, single vec_valid {11,12,13,14}.
- vec_stall=1, send vectors A,B -> A pending, s_ready=0 on B's last beat. Release stall -> A emitted, B's last beat accepted same cycle, then B emitted; vec_count=2.
- Assert rst while ch_idx=2 and pend_full=1 -> all outputs 0 next cycle; the following full vector emits normally with vec_count=1.
